// File: rtl/sprite_motion_unit_if.sv
// Bundles the sprite motion unit's video-timing input, keycode input and the
// outputs that go to the colour mapper.
interface sprite_motion_unit_if #(
  parameter int COORD_W  = 11,
  parameter int NUM_KEYS = 2,
  parameter int ANIM_W   = 2
);
  logic                    vsync;
  logic [8*NUM_KEYS-1:0]   Keycode;
  logic [COORD_W-1:0]      sprite_x;
  logic [COORD_W-1:0]      sprite_y;
  logic [3:0]              motion;
  logic [ANIM_W-1:0]       anim_frame;
  logic                    frame_tick;

  // Side that supplies sync and keycodes and consumes sprite state.
  modport master (
    output vsync, Keycode,
    input  sprite_x, sprite_y, motion, anim_frame, frame_tick
  );

  // The sprite motion unit itself.
  modport slave (
    input  vsync, Keycode,
    output sprite_x, sprite_y, motion, anim_frame, frame_tick
  );
endinterface

// File: rtl/sprite_motion_unit.sv
// Sprite motion unit: synchronises VGA vsync into the system clock, divides
// frames down to position updates, decodes HID keycodes into a direction and
// moves the sprite by STEP pixels inside a clamped bounding box.
module sprite_motion_unit #(
  parameter int COORD_W     = 11,
  parameter int NUM_KEYS    = 2,
  parameter int FRAME_DIV   = 4,
  parameter int STEP        = 2,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int Y_MIN       = 0,
  parameter int Y_MAX       = 448,
  parameter int X_INIT      = 320,
  parameter int Y_INIT      = 240,
  parameter int ANIM_FRAMES = 4,
  parameter int ANIM_W      = 2
) (
  input logic                Clk,
  input logic                Reset_n,
  sprite_motion_unit_if.slave bus
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int CW1   = COORD_W + 1;

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [ANIM_W-1:0]  ANIM_LAST = ANIM_W'(ANIM_FRAMES - 1);

  // Extended-width constants keep the clamp comparisons free of wrap-around.
  localparam logic [CW1-1:0]     STEP_E  = CW1'(STEP);
  localparam logic [CW1-1:0]     X_MIN_E = CW1'(X_MIN);
  localparam logic [CW1-1:0]     X_MAX_E = CW1'(X_MAX);
  localparam logic [CW1-1:0]     Y_MIN_E = CW1'(Y_MIN);
  localparam logic [CW1-1:0]     Y_MAX_E = CW1'(Y_MAX);
  localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_MIN_C = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN_C = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
  localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);

  localparam logic [3:0] MOT_IDLE  = 4'd0;
  localparam logic [3:0] MOT_UP    = 4'd1;
  localparam logic [3:0] MOT_LEFT  = 4'd2;
  localparam logic [3:0] MOT_DOWN  = 4'd3;
  localparam logic [3:0] MOT_RIGHT = 4'd4;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  typedef enum logic [1:0] {WAIT, DECODE, UPDATE} state_t;

  state_t               state_reg;
  logic                 sync1_reg, sync2_reg, prev_reg, tick_reg;
  logic [DIV_W-1:0]     div_reg;
  logic                 update_req;
  logic [3:0]           dir_reg, dec_dir, motion_reg;
  logic [COORD_W-1:0]   x_reg, y_reg, x_next, y_next;
  logic [ANIM_W-1:0]    anim_reg, anim_next;
  logic [CW1-1:0]       x_ext, y_ext, x_sum, y_sum;
  logic [COORD_W-1:0]   x_diff, y_diff;
  logic [NUM_KEYS-1:0][3:0] slot_dir;

  // Two-flop synchroniser plus a previous-value flop; the registered tick
  // fires once on the falling edge. Reset to 1 so release never looks like
  // an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      prev_reg  <= 1'b1;
      tick_reg  <= 1'b0;
    end else begin
      sync1_reg <= bus.vsync;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      tick_reg  <= prev_reg & ~sync2_reg;
    end
  end

  // Frame divider: counts ticks and wraps on the tick that requests an update.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_reg <= '0;
    end else if (tick_reg) begin
      div_reg <= (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    end
  end

  assign update_req = tick_reg && (div_reg == DIV_LAST);

  // Each keycode slot maps independently to a direction code.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_slot
    logic [7:0] key;
    assign key = bus.Keycode[8*gi +: 8];
    assign slot_dir[gi] = (key == KEY_W) ? MOT_UP    :
                          (key == KEY_A) ? MOT_LEFT  :
                          (key == KEY_S) ? MOT_DOWN  :
                          (key == KEY_D) ? MOT_RIGHT : MOT_IDLE;
  end

  // Lowest-numbered matching slot wins: scan downward so it is applied last.
  always_comb begin
    dec_dir = MOT_IDLE;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (slot_dir[i] != MOT_IDLE) dec_dir = slot_dir[i];
    end
  end

  assign x_ext  = {1'b0, x_reg};
  assign y_ext  = {1'b0, y_reg};
  assign x_sum  = x_ext + STEP_E;
  assign y_sum  = y_ext + STEP_E;
  assign x_diff = x_reg - STEP_C;
  assign y_diff = y_reg - STEP_C;

  // Clamped next position and next animation frame for the latched direction.
  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    case (dir_reg)
      MOT_UP:    y_next = (y_ext < Y_MIN_E + STEP_E) ? Y_MIN_C : y_diff;
      MOT_DOWN:  y_next = (y_sum > Y_MAX_E) ? Y_MAX_C : y_sum[COORD_W-1:0];
      MOT_LEFT:  x_next = (x_ext < X_MIN_E + STEP_E) ? X_MIN_C : x_diff;
      MOT_RIGHT: x_next = (x_sum > X_MAX_E) ? X_MAX_C : x_sum[COORD_W-1:0];
      default:   ;
    endcase
    if (dir_reg == MOT_IDLE)        anim_next = '0;
    else if (anim_reg == ANIM_LAST) anim_next = '0;
    else                            anim_next = anim_reg + 1'b1;
  end

  // Update sequencer: latch the direction once, then commit all outputs together.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg  <= WAIT;
      dir_reg    <= MOT_IDLE;
      x_reg      <= X_INIT_C;
      y_reg      <= Y_INIT_C;
      motion_reg <= MOT_IDLE;
      anim_reg   <= '0;
    end else begin
      case (state_reg)
        WAIT: begin
          if (update_req) state_reg <= DECODE;
        end
        DECODE: begin
          dir_reg   <= dec_dir;
          state_reg <= UPDATE;
        end
        UPDATE: begin
          x_reg      <= x_next;
          y_reg      <= y_next;
          motion_reg <= dir_reg;
          anim_reg   <= anim_next;
          state_reg  <= WAIT;
        end
        default: state_reg <= WAIT;
      endcase
    end
  end

  assign bus.sprite_x   = x_reg;
  assign bus.sprite_y   = y_reg;
  assign bus.motion     = motion_reg;
  assign bus.anim_frame = anim_reg;
  assign bus.frame_tick = tick_reg;

endmodule

// File: tb/tb_sprite_motion_unit.sv
// Bench for sprite_motion_unit: two instances (default parameters, and one
// started next to the bounds with FRAME_DIV=1) driven frame by frame and
// compared with a behavioural model of the motion rules.
module tb_sprite_motion_unit;

  localparam int STEP = 2, XMIN = 0, XMAX = 608, YMIN = 0, YMAX = 448, AF = 4;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  sprite_motion_unit_if #(.COORD_W(11), .NUM_KEYS(2), .ANIM_W(2)) bus0 ();
  sprite_motion_unit_if #(.COORD_W(11), .NUM_KEYS(2), .ANIM_W(2)) bus1 ();

  sprite_motion_unit dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave));
  sprite_motion_unit #(.X_INIT(607), .Y_INIT(1), .FRAME_DIV(1)) dut1 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus1.slave));

  // Reference model state, one entry per instance
  int m_x[2], m_y[2], m_mot[2], m_anim[2], m_div[2];
  int p_div[2] = '{4, 1};
  int p_xi[2]  = '{320, 607};
  int p_yi[2]  = '{240, 1};

  function automatic int decode(input logic [15:0] kc);
    logic [7:0] k;
    for (int i = 0; i < 2; i++) begin
      k = kc[8*i +: 8];
      if (k == 8'h1A) return 1;
      if (k == 8'h04) return 2;
      if (k == 8'h16) return 3;
      if (k == 8'h07) return 4;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < 2; w++) begin
      m_x[w] = p_xi[w]; m_y[w] = p_yi[w];
      m_mot[w] = 0; m_anim[w] = 0; m_div[w] = 0;
    end
  endtask

  // One vsync frame; the keycode given is the one present when decoding.
  task automatic model_frame(input int w, input logic [15:0] kc, output bit chg);
    int ox, oy, om, oa, d;
    bit upd;
    ox = m_x[w]; oy = m_y[w]; om = m_mot[w]; oa = m_anim[w];
    upd = (m_div[w] == p_div[w] - 1);
    m_div[w] = upd ? 0 : m_div[w] + 1;
    if (upd) begin
      d = decode(kc);
      case (d)
        1: m_y[w] = (m_y[w] < YMIN + STEP) ? YMIN : m_y[w] - STEP;
        2: m_x[w] = (m_x[w] < XMIN + STEP) ? XMIN : m_x[w] - STEP;
        3: m_y[w] = (m_y[w] + STEP > YMAX) ? YMAX : m_y[w] + STEP;
        4: m_x[w] = (m_x[w] + STEP > XMAX) ? XMAX : m_x[w] + STEP;
        default: ;
      endcase
      m_mot[w]  = d;
      m_anim[w] = (d == 0) ? 0 : (m_anim[w] + 1) % AF;
    end
    chg = (ox != m_x[w]) || (oy != m_y[w]) || (om != m_mot[w]) || (oa != m_anim[w]);
  endtask

  task automatic get_obs(input int w, output int x, output int y, output int mot,
                         output int anim, output bit tick);
    if (w == 0) begin
      x = bus0.sprite_x; y = bus0.sprite_y; mot = bus0.motion;
      anim = bus0.anim_frame; tick = bus0.frame_tick;
    end else begin
      x = bus1.sprite_x; y = bus1.sprite_y; mot = bus1.motion;
      anim = bus1.anim_frame; tick = bus1.frame_tick;
    end
  endtask

  task automatic set_in(input int w, input logic vs, input logic [15:0] kc);
    if (w == 0) begin bus0.vsync = vs; bus0.Keycode = kc; end
    else        begin bus1.vsync = vs; bus1.Keycode = kc; end
  endtask

  // Drives one frame (vsync low 10 cycles, high 10), recording at which edge
  // (counted from the first edge sampling vsync low) the tick and any output
  // change appear. Keycode switches to kc_after just after edge sw_edge.
  task automatic do_frame(input int w, input logic [15:0] kc, input logic [15:0] kc_after,
                          input int sw_edge, output int tick_cnt, output int tick_edge,
                          output int change_edge, output bit exp_chg);
    int sx, sy, sm, sa, x, y, m, a;
    bit t;
    logic [15:0] cur;
    tick_cnt = 0; tick_edge = 0; change_edge = 0;
    cur = kc;
    @(negedge Clk);
    set_in(w, 1'b0, cur);
    get_obs(w, sx, sy, sm, sa, t);
    for (int e = 1; e <= 20; e++) begin
      @(posedge Clk); #1;
      get_obs(w, x, y, m, a, t);
      if (t) begin
        tick_cnt++;
        if (tick_edge == 0) tick_edge = e;
      end
      if (change_edge == 0 && (x != sx || y != sy || m != sm || a != sa)) change_edge = e;
      if (e == sw_edge) cur = kc_after;
      set_in(w, (e >= 10), cur);
    end
    model_frame(w, kc, exp_chg);
  endtask

  task automatic test_reset();
    int x, y, m, a, ticks;
    bit t;
    Reset_n = 1'b0;
    set_in(0, 1'b1, 16'h0);
    set_in(1, 1'b1, 16'h0);
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      get_obs(w, x, y, m, a, t);
      checks++;
      if (x !== m_x[w] || y !== m_y[w] || m !== 0 || a !== 0 || t !== 1'b0) begin
        errors++;
        $display("FAIL reset_values dut%0d: got x=%0d y=%0d mot=%0d anim=%0d tick=%0d expected x=%0d y=%0d mot=0 anim=0 tick=0",
                 w, x, y, m, a, t, m_x[w], m_y[w]);
      end
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    ticks = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (bus0.frame_tick || bus1.frame_tick) ticks++;
    end
    checks++;
    if (ticks !== 0) begin
      errors++;
      $display("FAIL reset_release_tick: got %0d ticks expected 0", ticks);
    end
  endtask

  task automatic test_tick_divide();
    int tc, te, ce, x, y, m, a;
    bit ec, t;
    for (int i = 0; i < 8; i++) begin
      do_frame(0, 16'h0007, 16'h0007, 0, tc, te, ce, ec);
      checks++;
      if (tc !== 1 || te !== 3) begin
        errors++;
        $display("FAIL tick_timing frame %0d: got count=%0d edge=%0d expected count=1 edge=3", i, tc, te);
      end
      checks++;
      if (ce !== ((i == 3 || i == 7) ? 6 : 0)) begin
        errors++;
        $display("FAIL divide_latency frame %0d: got change edge %0d expected %0d",
                 i, ce, (i == 3 || i == 7) ? 6 : 0);
      end
      if (i == 3 || i == 7) begin
        get_obs(0, x, y, m, a, t);
        checks++;
        if (x !== ((i == 3) ? 322 : 324) || m !== 4 || y !== 240) begin
          errors++;
          $display("FAIL divide_move frame %0d: got x=%0d y=%0d mot=%0d expected x=%0d y=240 mot=4",
                   i, x, y, m, (i == 3) ? 322 : 324);
        end
      end
    end
  endtask

  task automatic test_priority();
    int tc, te, ce, x, y, m, a;
    bit ec, t;
    for (int i = 0; i < 4; i++) do_frame(0, 16'h041A, 16'h041A, 0, tc, te, ce, ec);
    get_obs(0, x, y, m, a, t);
    checks++;
    if (m !== 1 || y !== 238 || x !== 324 || ce !== 6) begin
      errors++;
      $display("FAIL priority: got mot=%0d x=%0d y=%0d edge=%0d expected mot=1 x=324 y=238 edge=6",
               m, x, y, ce);
    end
  endtask

  task automatic test_idle_window();
    int tc, te, ce, x, y, m, a;
    bit ec, t;
    for (int i = 0; i < 4; i++) do_frame(0, 16'h0016, 16'h0000, 5, tc, te, ce, ec);
    get_obs(0, x, y, m, a, t);
    checks++;
    if (m !== 3 || y !== 240 || ce !== 6) begin
      errors++;
      $display("FAIL sample_window: got mot=%0d y=%0d edge=%0d expected mot=3 y=240 edge=6", m, y, ce);
    end
    for (int i = 0; i < 4; i++) do_frame(0, 16'h0000, 16'h0000, 0, tc, te, ce, ec);
    get_obs(0, x, y, m, a, t);
    checks++;
    if (m !== 0 || a !== 0 || y !== 240 || x !== 324) begin
      errors++;
      $display("FAIL idle_update: got mot=%0d anim=%0d x=%0d y=%0d expected mot=0 anim=0 x=324 y=240",
               m, a, x, y);
    end
  endtask

  task automatic test_random();
    int tc, te, ce, x, y, m, a, sw;
    bit ec, t;
    logic [15:0] kc, ka;
    logic [7:0] pool [6];
    pool[0] = 8'h1A; pool[1] = 8'h04; pool[2] = 8'h16; pool[3] = 8'h07; pool[4] = 8'h00;
    for (int i = 0; i < 32; i++) begin
      pool[5] = 8'($urandom_range(0, 255));
      kc = {pool[$urandom_range(0, 5)], pool[$urandom_range(0, 5)]};
      ka = 16'($urandom);
      sw = 5 + $urandom_range(0, 5);
      do_frame(0, kc, ka, sw, tc, te, ce, ec);
      get_obs(0, x, y, m, a, t);
      checks++;
      if (x !== m_x[0] || y !== m_y[0] || m !== m_mot[0] || a !== m_anim[0]) begin
        errors++;
        $display("FAIL random_state %0d kc=%h: got x=%0d y=%0d mot=%0d anim=%0d expected x=%0d y=%0d mot=%0d anim=%0d",
                 i, kc, x, y, m, a, m_x[0], m_y[0], m_mot[0], m_anim[0]);
      end
      checks++;
      if (tc !== 1 || ce !== (ec ? 6 : 0)) begin
        errors++;
        $display("FAIL random_timing %0d: got ticks=%0d change edge=%0d expected ticks=1 edge=%0d",
                 i, tc, ce, ec ? 6 : 0);
      end
    end
  endtask

  task automatic test_clamp();
    int tc, te, ce, x, y, m, a;
    bit ec, t;
    int exp_anim [5] = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      do_frame(1, 16'h0007, 16'h0007, 0, tc, te, ce, ec);
      get_obs(1, x, y, m, a, t);
      checks++;
      if (x !== 608 || y !== 1 || a !== exp_anim[i] || a !== m_anim[1] || ce !== 6) begin
        errors++;
        $display("FAIL clamp_right %0d: got x=%0d y=%0d anim=%0d edge=%0d expected x=608 y=1 anim=%0d edge=6",
                 i, x, y, a, ce, exp_anim[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      do_frame(1, 16'h001A, 16'h001A, 0, tc, te, ce, ec);
      get_obs(1, x, y, m, a, t);
      checks++;
      if (y !== 0 || x !== 608 || m !== 1 || a !== m_anim[1]) begin
        errors++;
        $display("FAIL clamp_up %0d: got x=%0d y=%0d mot=%0d anim=%0d expected x=608 y=0 mot=1 anim=%0d",
                 i, x, y, m, a, m_anim[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int tc, te, ce, x, y, m, a;
    bit ec, t;
    for (int i = 0; i < 4; i++) do_frame(0, 16'h0007, 16'h0007, 0, tc, te, ce, ec);
    for (int i = 0; i < 3; i++) do_frame(0, 16'h0007, 16'h0007, 0, tc, te, ce, ec);
    get_obs(0, x, y, m, a, t);
    checks++;
    if (m !== 4 || x !== m_x[0]) begin
      errors++;
      $display("FAIL pre_reset_state: got mot=%0d x=%0d expected mot=4 x=%0d", m, x, m_x[0]);
    end
    // Enter the update frame and stop in DECODE (4 edges after the sample).
    @(negedge Clk);
    set_in(0, 1'b0, 16'h0007);
    repeat (4) @(posedge Clk);
    #1;
    Reset_n = 1'b0;
    #1;
    model_reset();
    get_obs(0, x, y, m, a, t);
    checks++;
    if (x !== 320 || y !== 240 || m !== 0 || a !== 0 || t !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got x=%0d y=%0d mot=%0d anim=%0d tick=%0d expected 320 240 0 0 0",
               x, y, m, a, t);
    end
    set_in(0, 1'b1, 16'h0000);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) @(posedge Clk);
    for (int i = 0; i < 4; i++) begin
      do_frame(0, 16'h0016, 16'h0016, 0, tc, te, ce, ec);
      checks++;
      if (ce !== ((i == 3) ? 6 : 0) || tc !== 1) begin
        errors++;
        $display("FAIL post_reset_latency frame %0d: got edge=%0d ticks=%0d expected edge=%0d ticks=1",
                 i, ce, tc, (i == 3) ? 6 : 0);
      end
    end
    get_obs(0, x, y, m, a, t);
    checks++;
    if (x !== 320 || y !== 242 || m !== 3 || a !== 1) begin
      errors++;
      $display("FAIL post_reset_move: got x=%0d y=%0d mot=%0d anim=%0d expected 320 242 3 1", x, y, m, a);
    end
  endtask

  initial begin
    test_reset();
    test_tick_divide();
    test_priority();
    test_idle_window();
    test_random();
    test_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_motion_unit.md
Name: sprite_motion_unit

Overview:
- Parametrised successor to the VSYNC-clocked sprite controller, the frame clock divider and the sprite state machine, merged into one block on the system clock.
- Samples VGA vertical sync and divides frames by a programmable ratio.
- On each update tick it decodes up to NUM_KEYS USB HID keycodes into a motion direction, then moves the sprite by STEP pixels with clamping to a bounding box.
- Drives position, motion select and an animation frame index to the colour mapper.

Parameters:
- COORD_W, 11, width of the sprite_x / sprite_y coordinates
- NUM_KEYS, 2, number of 8-bit keycode slots in Keycode
- FRAME_DIV, 4, frames per position update (at least 1)
- STEP, 2, pixels moved per update
- X_MIN, 0 / X_MAX, 608, horizontal clamp bounds (inclusive)
- Y_MIN, 0 / Y_MAX, 448, vertical clamp bounds (inclusive)
- X_INIT, 320 / Y_INIT, 240, reset position
- ANIM_FRAMES, 4, animation frames per walk cycle (at least 2)
- ANIM_W, 2, width of anim_frame, equal to ceil(log2(ANIM_FRAMES))

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- vsync  in  1  VGA vertical sync, active low, asynchronous to Clk
- Keycode  in  8*NUM_KEYS  HID keycodes; slot 0 is bits [7:0]
- sprite_x  out  COORD_W  sprite top-left X
- sprite_y  out  COORD_W  sprite top-left Y
- motion  out  4  0 idle, 1 up, 2 left, 3 down, 4 right
- anim_frame  out  ANIM_W  walk-cycle frame index
- frame_tick  out  1  one-cycle pulse per detected vsync falling edge

Behaviour:
- Reset values (asynchronous, Reset_n=0): sprite_x=X_INIT, sprite_y=Y_INIT, motion=0, anim_frame=0, frame_tick=0, divider=0, FSM=WAIT.
  - Both vsync synchroniser flops and the previous-value flop reset to 1, so no false edge occurs at reset release.
  - Reset asserted mid-update aborts the update; no partial position is kept.
- Synchroniser: vsync passes through 2 flops, then a previous-value flop.
  - frame_tick=1 for exactly one cycle, visible after the 3rd rising edge of Clk counted from the first edge that samples vsync low.
  - vsync low for several frames produces no further ticks. A vsync glitch narrower than one Clk period may be missed; this is acceptable.
- Divider: counts 0..FRAME_DIV-1 and increments on each frame_tick.
  - update_req = frame_tick AND divider==FRAME_DIV-1; on that cycle the divider wraps to 0.
  - FRAME_DIV=1 means every frame is an update.
- FSM states: WAIT, DECODE, UPDATE.
  - WAIT goes to DECODE on the edge where update_req=1; otherwise stays in WAIT.
  - DECODE: Keycode is sampled once and direction is latched. Slots are scanned from 0 upward; the first slot holding 0x1A (W, up), 0x04 (A, left), 0x16 (S, down) or 0x07 (D, right) wins. If none match, direction is idle. Next state is UPDATE.
  - UPDATE: motion, position and anim_frame are registered. Next state is WAIT.
  - Keycode changes outside DECODE are ignored.
  - update_req arriving while not in WAIT is dropped. It cannot occur for FRAME_DIV of at least 1 at legal frame rates.
- Latency: outputs change after the 6th Clk edge counted from the edge that samples vsync low (frame_tick at 3, DECODE at 4, UPDATE at 5, outputs registered at 6).
- Arithmetic: computed at COORD_W+1 bits, unsigned.
  - Right/down: if pos+STEP > MAX then pos=MAX, else pos=pos+STEP.
  - Left/up: if pos < MIN+STEP then pos=MIN, else pos=pos-STEP.
  - The axis not selected holds its value. Coordinates never wrap.
- Animation:
  - In UPDATE with a non-idle direction, anim_frame increments and wraps from ANIM_FRAMES-1 to 0. This includes moves that are clamped at a bound.
  - An idle direction sets anim_frame to 0.
  - A direction change does not reset anim_frame.
- motion changes only in UPDATE and holds between updates.

Test Plan:
- Reset: Reset_n=0 for 3 cycles with vsync=1 -> sprite_x=320, sprite_y=240, motion=0, anim_frame=0. Release reset with vsync=1 -> frame_tick never asserts.
- Tick and divide: FRAME_DIV=4, 8 vsync falling edges with Keycode=0x0007 -> 8 frame_tick pulses, each 3 edges after its sample. sprite_x goes 320 -> 322 -> 324; each change occurs 6 edges after the 4th and 8th vsync falls. motion=4.
- Priority: Keycode=0x041A (slot0=W, slot1=A) at an update -> motion=1, sprite_y 240 -> 238, sprite_x unchanged.
- Clamp: sprite_x=607, D held -> 608, then stays 608 on later updates. anim_frame still goes 0,1,2,3,0. sprite_y=1 with W held -> 0 and holds.
- Idle and sampling window: Keycode=0x0016 at an update, then 0x0000 one cycle after DECODE -> this update moves down (240 -> 242). The next update gives motion=0, anim_frame=0 and no movement.
- Reset mid-operation: assert Reset_n=0 during the DECODE state -> outputs return to their reset values immediately (asynchronously). After release, the next update follows the normal 6-edge latency.
